// File: rtl/nic_host_pkg.sv
// Shared definitions for the NIC host agent: NIC register map, status bit
// layout and the access-sequencer state type.
package nic_host_pkg;

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    localparam int STAT_FULL_BIT = 0;

    typedef enum logic [2:0] {
        IDLE,
        TX_STAT,
        TX_STAT_W,
        TX_WRITE,
        RX_STAT,
        RX_STAT_W,
        RX_READ,
        RX_READ_W
    } state_t;

    typedef enum logic {
        PATH_RX = 1'b0,
        PATH_TX = 1'b1
    } path_t;

endpackage

// File: rtl/nic_host_agent.sv
// Host-side agent for a register-mapped NIC: polls status, moves one local
// packet out per write and one received packet in per read, fair between paths.
module nic_host_agent #(
    parameter int PACKET_WIDTH = 64,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    input  logic [PACKET_WIDTH-1:0] tx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic [PACKET_WIDTH-1:0] rx_data,
    output logic [1:0]              addr,
    output logic [PACKET_WIDTH-1:0] d_out,
    input  logic [PACKET_WIDTH-1:0] d_in,
    output logic                    nicEn,
    output logic                    nicEnWR,
    output logic [CNT_WIDTH-1:0]    tx_count,
    output logic [CNT_WIDTH-1:0]    rx_count
);
    import nic_host_pkg::*;

    state_t state;
    path_t  last_served;

    logic tx_elig;
    logic rx_elig;
    logic take_tx;
    logic stat_full;

    // RX may start while a packet is held only if the sink drains it this cycle.
    always_comb begin
        tx_elig = tx_valid;
        rx_elig = !rx_valid || rx_ready;
        take_tx = tx_elig && (!rx_elig || last_served == PATH_RX);
    end

    assign stat_full = d_in[STAT_FULL_BIT];

    // Bus outputs are registered alongside the state, so a NIC access is
    // visible in exactly the cycle the FSM sits in the access state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_served <= PATH_RX;
            tx_ready    <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            addr        <= '0;
            d_out       <= '0;
            nicEn       <= 1'b0;
            nicEnWR     <= 1'b0;
            tx_count    <= '0;
            rx_count    <= '0;
        end else begin
            nicEn    <= 1'b0;
            nicEnWR  <= 1'b0;
            addr     <= '0;
            d_out    <= '0;
            tx_ready <= 1'b0;

            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (take_tx) begin
                        state <= TX_STAT;
                        nicEn <= 1'b1;
                        addr  <= ADDR_OUT_STAT;
                    end else if (rx_elig) begin
                        state <= RX_STAT;
                        nicEn <= 1'b1;
                        addr  <= ADDR_IN_STAT;
                    end
                end
                TX_STAT:   state <= TX_STAT_W;
                TX_STAT_W: begin
                    if (stat_full) begin
                        state       <= IDLE;
                        last_served <= PATH_TX;
                    end else begin
                        state    <= TX_WRITE;
                        nicEn    <= 1'b1;
                        nicEnWR  <= 1'b1;
                        addr     <= ADDR_OUT_BUF;
                        d_out    <= tx_data;
                        tx_ready <= 1'b1;
                    end
                end
                TX_WRITE: begin
                    state       <= IDLE;
                    last_served <= PATH_TX;
                    tx_count    <= tx_count + 1'b1;
                end
                RX_STAT:   state <= RX_STAT_W;
                RX_STAT_W: begin
                    if (stat_full) begin
                        state <= RX_READ;
                        nicEn <= 1'b1;
                        addr  <= ADDR_IN_BUF;
                    end else begin
                        state       <= IDLE;
                        last_served <= PATH_RX;
                    end
                end
                RX_READ:   state <= RX_READ_W;
                RX_READ_W: begin
                    rx_data     <= d_in;
                    rx_valid    <= 1'b1;
                    rx_count    <= rx_count + 1'b1;
                    state       <= IDLE;
                    last_served <= PATH_RX;
                end
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nic_host_agent.sv
// Bench for nic_host_agent: a behavioural NIC plus transaction scoreboard,
// directed vector tables, multi-cycle corner sequences and a random soak.
module tb_nic_host_agent;
    import nic_host_pkg::*;

    localparam int PW = 64;
    localparam int CW = 8;  // narrow counters keep the wrap case short

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [PW-1:0] tx_data  = '0;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [PW-1:0] rx_data;
    logic [1:0]    addr;
    logic [PW-1:0] d_out;
    logic [PW-1:0] d_in     = '0;
    logic          nicEn;
    logic          nicEnWR;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;

    always #5 clk = ~clk;

    nic_host_agent #(.PACKET_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .addr(addr), .d_out(d_out), .d_in(d_in),
        .nicEn(nicEn), .nicEnWR(nicEnWR),
        .tx_count(tx_count), .rx_count(rx_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // NIC-side state owned by the stimulus process
    logic        out_full = 1'b0;
    logic        in_full  = 1'b0;
    logic [63:0] in_buf   = '0;
    bit          alt_en   = 1'b0;

    // Scoreboard state owned by the monitor
    int          wr_cnt, rd_in_cnt, tx_acc, rx_got, stat01_cnt, stat11_cnt;
    bit          last_in_stat, last_out_stat, held, alt_have;
    logic [63:0] held_data;
    logic [1:0]  alt_prev;
    logic [63:0] rx_exp[$];

    // NIC register model and transaction checker, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            wr_cnt = 0; rd_in_cnt = 0; tx_acc = 0; rx_got = 0;
            stat01_cnt = 0; stat11_cnt = 0;
            last_in_stat = 1'b0; last_out_stat = 1'b1;
            held = 1'b0; alt_have = 1'b0;
            rx_exp.delete();
        end else begin
            if (!nicEn) begin
                chk("idle_addr", 64'(addr), 64'd0);
                chk("idle_dout", d_out, 64'd0);
            end
            chk("ready_is_write", 64'(tx_ready), 64'(nicEn && nicEnWR));
            if (tx_ready) tx_acc++;
            if (nicEn && nicEnWR) begin
                wr_cnt++;
                chk("wr_addr", 64'(addr), 64'(ADDR_OUT_BUF));
                chk("wr_data", d_out, tx_data);
                chk("wr_offered", 64'(tx_valid), 64'd1);
                chk("wr_after_not_full", 64'(last_out_stat), 64'd0);
                last_out_stat = 1'b1;
            end else if (nicEn) begin
                case (addr)
                    ADDR_IN_BUF: begin
                        chk("rd_after_in_full", 64'(last_in_stat), 64'd1);
                        last_in_stat = 1'b0;
                        d_in = in_buf;
                        rx_exp.push_back(in_buf);
                        rd_in_cnt++;
                    end
                    ADDR_IN_STAT: begin
                        d_in = 64'(in_full);
                        last_in_stat = in_full;
                        stat01_cnt++;
                    end
                    ADDR_OUT_STAT: begin
                        d_in = 64'(out_full);
                        last_out_stat = out_full;
                        stat11_cnt++;
                    end
                    default: chk("read_of_out_buf", 64'(addr), 64'(ADDR_OUT_STAT));
                endcase
                if (alt_en && addr != ADDR_IN_BUF) begin
                    if (alt_have) chk("alternate", 64'(addr != alt_prev), 64'd1);
                    alt_have = 1'b1;
                    alt_prev = addr;
                end
            end
            if (!alt_en) alt_have = 1'b0;
            if (held) begin
                chk("rx_hold_valid", 64'(rx_valid), 64'd1);
                chk("rx_hold_data", rx_data, held_data);
            end
            if (rx_valid && rx_ready) begin
                rx_got++;
                chk("rx_queued", 64'(rx_exp.size() != 0), 64'd1);
                if (rx_exp.size() != 0) chk("rx_data", rx_data, rx_exp.pop_front());
            end
            held      = rx_valid && !rx_ready;
            held_data = rx_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tx_ready"}, 64'(tx_ready), 64'd0);
        chk({tag, "_rx_valid"}, 64'(rx_valid), 64'd0);
        chk({tag, "_rx_data"},  rx_data,       64'd0);
        chk({tag, "_addr"},     64'(addr),     64'd0);
        chk({tag, "_d_out"},    d_out,         64'd0);
        chk({tag, "_nicEn"},    64'(nicEn),    64'd0);
        chk({tag, "_nicEnWR"},  64'(nicEnWR),  64'd0);
        chk({tag, "_tx_count"}, 64'(tx_count), 64'd0);
        chk({tag, "_rx_count"}, 64'(rx_count), 64'd0);
    endtask

    int tx_seen, rd_seen;

    // One cycle of the self-running environment: TX source and NIC input buffer.
    task automatic env_step(input int tx_prob);
        tick();
        if (tx_acc != tx_seen) begin
            tx_seen  = tx_acc;
            tx_valid = 1'b0;
        end
        if (!tx_valid && $urandom_range(0, 99) < tx_prob) begin
            tx_valid = 1'b1;
            tx_data  = rand64();
        end
        if (rd_in_cnt != rd_seen) begin
            rd_seen = rd_in_cnt;
            in_buf  = rand64();
        end
    endtask

    typedef struct { int polls; logic [63:0] data; int exp_lat; } tx_vec_t;
    typedef struct { logic [63:0] data; int exp_lat; } rx_vec_t;

    tx_vec_t tv[3];
    rx_vec_t rv[2];

    initial begin
        int lat, p, q, diff;
        bit found;

        // a full-poll round costs one TX no-op plus one RX no-op, 6 cycles
        tv[0] = '{0, 64'hDEAD_BEEF_0000_0001, 3};
        tv[1] = '{5, 64'h1111_2222_3333_4444, 33};
        tv[2] = '{2, 64'hFEDC_BA98_7654_3210, 15};
        rv[0] = '{64'h0123_4567_89AB_CDEF, 4};
        rv[1] = '{64'h8000_0000_0000_0001, 4};

        #1 reset = 1'b0;
        #1 check_zero("rst");
        do_reset();

        foreach (tv[i]) begin
            tx_valid = 1'b1; tx_data = tv[i].data;
            out_full = (tv[i].polls > 0); in_full = 1'b0; rx_ready = 1'b1;
            do_reset();
            lat = -1;
            for (int c = 1; c <= 300 && lat < 0; c++) begin
                tick();
                if (out_full && stat11_cnt >= tv[i].polls) out_full = 1'b0;
                if (nicEn && nicEnWR) lat = c;
            end
            chk("tx_latency", 64'(lat), 64'(tv[i].exp_lat));
            chk("tx_status_polls", 64'(stat11_cnt), 64'(tv[i].polls + 1));
            tick();
            tx_valid = 1'b0;
            repeat (8) tick();
            chk("tx_ready_pulses", 64'(tx_acc), 64'd1);
            chk("tx_writes", 64'(wr_cnt), 64'd1);
            chk("tx_count_one", 64'(tx_count), 64'd1);
        end

        foreach (rv[i]) begin
            tx_valid = 1'b0; out_full = 1'b0;
            in_full = 1'b1; in_buf = rv[i].data; rx_ready = 1'b0;
            do_reset();
            p = -1; q = -1;
            for (int c = 1; c <= 40 && q < 0; c++) begin
                tick();
                if (p < 0 && nicEn && addr == ADDR_IN_STAT) p = c;
                if (rx_valid) q = c;
            end
            chk("rx_latency", 64'(q - p), 64'(rv[i].exp_lat));
            chk("rx_capture", rx_data, rv[i].data);
            repeat (10) tick();
            chk("rx_no_repoll", 64'(stat01_cnt), 64'd1);
            chk("rx_count_one", 64'(rx_count), 64'd1);
            chk("rx_still_held", 64'(rx_valid), 64'd1);
            in_full = 1'b0; rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
            tick();
            chk("rx_released", 64'(rx_valid), 64'd0);
            chk("rx_delivered", 64'(rx_got), 64'd1);
        end

        // Both paths permanently eligible: service must alternate.
        tx_valid = 1'b1; tx_data = rand64(); out_full = 1'b0;
        in_full = 1'b1; in_buf = rand64(); rx_ready = 1'b1; alt_en = 1'b1;
        do_reset();
        tx_seen = 0; rd_seen = 0;
        for (int g = 0; g < 2000 && tx_acc < 20; g++) env_step(100);
        tx_valid = 1'b0; alt_en = 1'b0; in_full = 1'b0;
        repeat (10) tick();
        chk("alt_tx_count", 64'(tx_count), 64'd20);
        chk("alt_rx_count", 64'(rx_count), 64'(rd_in_cnt % 256));
        diff = tx_acc - rd_in_cnt;
        chk("alt_balance", 64'(diff >= -1 && diff <= 1), 64'd1);
        chk("alt_rx_delivered", 64'(rx_got), 64'(rd_in_cnt));

        // rx_count wrap: all-ones, then one more read returns it to zero.
        tx_valid = 1'b0; in_full = 1'b1; rx_ready = 1'b1;
        do_reset();
        tx_seen = 0; rd_seen = 0;
        for (int g = 0; g < 3000 && rd_in_cnt < 255; g++) env_step(0);
        in_full = 1'b0;
        repeat (6) tick();
        chk("wrap_all_ones", 64'(rx_count), 64'd255);
        in_full = 1'b1;
        for (int g = 0; g < 50 && rd_in_cnt < 256; g++) env_step(0);
        in_full = 1'b0;
        repeat (6) tick();
        chk("wrap_to_zero", 64'(rx_count), 64'd0);
        chk("wrap_delivered", 64'(rx_got), 64'd256);

        // Reset landing on the write cycle, with an RX packet likely held.
        tx_valid = 1'b1; tx_data = 64'hCAFE_F00D_1234_5678; out_full = 1'b0;
        in_full = 1'b1; in_buf = 64'h5555_AAAA_0F0F_F0F0; rx_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            tick();
            if (nicEn && nicEnWR) found = 1'b1;
        end
        chk("reach_write", 64'(found), 64'd1);
        reset = 1'b0;
        #1 check_zero("mid_write");
        @(negedge clk);
        #2 reset = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            tick();
            if (c == 1) chk("restart_tx_count", 64'(tx_count), 64'd0);
            if (nicEn && nicEnWR) lat = c;
        end
        chk("restart_latency", 64'(lat), 64'd3);
        tick();
        tx_valid = 1'b0;
        repeat (4) tick();
        chk("restart_one_write", 64'(tx_count), 64'd1);

        // Random soak against the scoreboard.
        tx_valid = 1'b0; in_full = 1'b0; out_full = 1'b0; rx_ready = 1'b1;
        do_reset();
        tx_seen = 0; rd_seen = 0;
        for (int c = 0; c < 3000; c++) begin
            env_step(30);
            out_full = ($urandom_range(0, 3) == 0);
            in_full  = ($urandom_range(0, 1) == 0);
            rx_ready = ($urandom_range(0, 2) != 0);
        end
        out_full = 1'b0; rx_ready = 1'b1;
        for (int g = 0; g < 300 && tx_valid; g++) env_step(0);
        in_full = 1'b0;
        repeat (20) env_step(0);
        chk("rand_tx_drained", 64'(tx_valid), 64'd0);
        chk("rand_tx_count", 64'(tx_count), 64'(wr_cnt % 256));
        chk("rand_rx_count", 64'(rx_count), 64'(rd_in_cnt % 256));
        chk("rand_pulses", 64'(tx_acc), 64'(wr_cnt));
        chk("rand_rx_drained", 64'(rx_exp.size()), 64'd0);
        chk("rand_rx_delivered", 64'(rx_got), 64'(rd_in_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
